// File: rtl/exu_wb_arbiter.sv
// Execute-stage writeback collector: per-channel result FIFOs drained by a
// fixed-priority or round-robin arbiter into one registered register-file write port.
module exu_wb_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NCH      = 5,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ARB_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NCH-1:0]       ch_valid,
  output logic [NCH-1:0]       ch_ready,
  input  logic [NCH*XLEN-1:0]  ch_data,
  input  logic [NCH*5-1:0]     ch_rd_addr,
  input  logic [NCH*XLEN-1:0]  ch_tag,
  input  logic [NCH*32-1:0]    ch_instr,
  output logic [XLEN-1:0]      wb_data,
  output logic [4:0]           wb_rd_addr,
  output logic                 wb_rd_wr_en,
  output logic [XLEN-1:0]      wb_tag,
  output logic [31:0]          wb_instr,
  input  logic [4:0]           pend_addr,
  output logic                 pend_hit,
  output logic                 wb_busy
);

  localparam int unsigned RD_W    = 5;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W   = $clog2(NCH);

  typedef struct packed {
    logic [XLEN-1:0]    data;
    logic [RD_W-1:0]    rd;
    logic [XLEN-1:0]    tag;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t             fifo_mem [NCH][DEPTH];
  entry_t             push_ent [NCH];
  logic [PTR_W-1:0]   wr_ptr   [NCH];
  logic [PTR_W-1:0]   rd_ptr   [NCH];
  logic [CNT_W-1:0]   count    [NCH];
  logic [NCH-1:0]     non_empty;
  logic [NCH-1:0]     push;
  logic [NCH-1:0]     pop;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_nxt;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  entry_t             head;
  logic [PTR_W-1:0]   slot_off;

  // Unpack channel payloads; ready reflects registered occupancy only
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      push_ent[i].data  = ch_data[i*XLEN +: XLEN];
      push_ent[i].rd    = ch_rd_addr[i*RD_W +: RD_W];
      push_ent[i].tag   = ch_tag[i*XLEN +: XLEN];
      push_ent[i].instr = ch_instr[i*INSTR_W +: INSTR_W];
      non_empty[i]      = (count[i] != '0);
      ch_ready[i]       = (count[i] != CNT_W'(DEPTH));
      push[i]           = ch_valid[i] & ch_ready[i];
    end
  end

  // Head selection: fixed priority from channel 0, or rotating from rr_ptr
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ARB_MODE == 1) begin
        cand = IDX_W'((32'(rr_ptr) + k) % NCH);
      end else begin
        cand = IDX_W'(k);
      end
      if (!gnt_vld && non_empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    head   = fifo_mem[gnt_idx][rd_ptr[gnt_idx]];
    pop    = gnt_vld ? (NCH'(1) << gnt_idx) : '0;
    rr_nxt = (gnt_idx == IDX_W'(NCH - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  // FIFO pointers and occupancy; flush discards everything including same-cycle pushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (!push[i] && pop[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!flush && push[i]) fifo_mem[i][wr_ptr[i]] <= push_ent[i];
    end
  end

  // Registered write port; rd = 0 entries consume the slot without a strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd_wr_en <= 1'b0;
      wb_data     <= '0;
      wb_rd_addr  <= '0;
      wb_tag      <= '0;
      wb_instr    <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      wb_rd_wr_en <= 1'b0;
      wb_data     <= '0;
      wb_rd_addr  <= '0;
      wb_tag      <= '0;
      wb_instr    <= '0;
    end else if (gnt_vld) begin
      wb_rd_wr_en <= (head.rd != '0);
      wb_data     <= head.data;
      wb_rd_addr  <= head.rd;
      wb_tag      <= head.tag;
      wb_instr    <= head.instr;
      rr_ptr      <= rr_nxt;
    end else begin
      wb_rd_wr_en <= 1'b0;
    end
  end

  // RAW query against every live FIFO slot and the output stage
  always_comb begin
    pend_hit = 1'b0;
    slot_off = '0;
    if (pend_addr != '0) begin
      if (wb_rd_wr_en && (wb_rd_addr == pend_addr)) pend_hit = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          slot_off = PTR_W'(j) - rd_ptr[i];
          if ((CNT_W'(slot_off) < count[i]) && (fifo_mem[i][j].rd == pend_addr)) begin
            pend_hit = 1'b1;
          end
        end
      end
    end
  end

  assign wb_busy = (|non_empty) | wb_rd_wr_en;

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Bench for exu_wb_arbiter: round-robin and fixed-priority instances share stimulus
// and are checked against a queue-based reference model plus directed scenarios.
module tb_exu_wb_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NCH   = 5;
  localparam int unsigned DEPTH = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic [NCH-1:0]      ch_valid = '0;
  logic [NCH*XLEN-1:0] ch_data = '0;
  logic [NCH*5-1:0]    ch_rd_addr = '0;
  logic [NCH*XLEN-1:0] ch_tag = '0;
  logic [NCH*32-1:0]   ch_instr = '0;
  logic [4:0]          pend_addr = '0;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic [NCH-1:0]  o_rdy   [2];
  logic            o_en    [2];
  logic [XLEN-1:0] o_data  [2];
  logic [4:0]      o_rd    [2];
  logic [XLEN-1:0] o_tag   [2];
  logic [31:0]     o_instr [2];
  logic            o_hit   [2];
  logic            o_busy  [2];

  always #5 clk = ~clk;

  exu_wb_arbiter #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ch_valid(ch_valid), .ch_ready(o_rdy[0]),
    .ch_data(ch_data), .ch_rd_addr(ch_rd_addr), .ch_tag(ch_tag), .ch_instr(ch_instr),
    .wb_data(o_data[0]), .wb_rd_addr(o_rd[0]), .wb_rd_wr_en(o_en[0]), .wb_tag(o_tag[0]),
    .wb_instr(o_instr[0]), .pend_addr(pend_addr), .pend_hit(o_hit[0]), .wb_busy(o_busy[0])
  );

  exu_wb_arbiter #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH), .ARB_MODE(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ch_valid(ch_valid), .ch_ready(o_rdy[1]),
    .ch_data(ch_data), .ch_rd_addr(ch_rd_addr), .ch_tag(ch_tag), .ch_instr(ch_instr),
    .wb_data(o_data[1]), .wb_rd_addr(o_rd[1]), .wb_rd_wr_en(o_en[1]), .wb_tag(o_tag[1]),
    .wb_instr(o_instr[1]), .pend_addr(pend_addr), .pend_hit(o_hit[1]), .wb_busy(o_busy[1])
  );

  typedef struct {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic [XLEN-1:0] tag;
    logic [31:0]     instr;
  } ent_t;

  ent_t mq [2][NCH][$];
  int   rrp [2];
  logic me_en [2];
  ent_t me [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NCH; i++) mq[m][i].delete();
      rrp[m]   = 0;
      me_en[m] = 1'b0;
      me[m]    = '{default: '0};
    end
  endtask

  // One clock edge of the reference: queues, arbitration order, flush priority
  task automatic model_step(input int m);
    bit   rdy [NCH];
    int   g;
    int   c;
    ent_t e;
    for (int i = 0; i < NCH; i++) rdy[i] = (mq[m][i].size() < DEPTH);
    if (flush) begin
      for (int i = 0; i < NCH; i++) mq[m][i].delete();
      me_en[m] = 1'b0;
      me[m]    = '{default: '0};
      return;
    end
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      c = (m == 0) ? (rrp[m] + k) % NCH : k;
      if (g < 0 && mq[m][c].size() > 0) g = c;
    end
    if (g >= 0) begin
      me[m]    = mq[m][g].pop_front();
      me_en[m] = (me[m].rd != 5'd0);
      rrp[m]   = (g + 1) % NCH;
    end else begin
      me_en[m] = 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (ch_valid[i] && rdy[i]) begin
        e.data  = ch_data[i*XLEN +: XLEN];
        e.rd    = ch_rd_addr[i*5 +: 5];
        e.tag   = ch_tag[i*XLEN +: XLEN];
        e.instr = ch_instr[i*32 +: 32];
        mq[m][i].push_back(e);
      end
    end
  endtask

  function automatic logic exp_hit(input int m);
    logic h = 1'b0;
    if (pend_addr != 5'd0) begin
      if (me_en[m] && me[m].rd == pend_addr) h = 1'b1;
      for (int i = 0; i < NCH; i++)
        for (int j = 0; j < mq[m][i].size(); j++)
          if (mq[m][i][j].rd == pend_addr) h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic exp_busy(input int m);
    logic b = me_en[m];
    for (int i = 0; i < NCH; i++) if (mq[m][i].size() > 0) b = 1'b1;
    return b;
  endfunction

  function automatic logic [NCH-1:0] exp_rdy(input int m);
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = (mq[m][i].size() < DEPTH);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [XLEN-1:0] d, input logic [4:0] rd);
    ch_valid[i]              = 1'b1;
    ch_data[i*XLEN +: XLEN]  = d;
    ch_rd_addr[i*5 +: 5]     = rd;
    ch_tag[i*XLEN +: XLEN]   = d ^ 32'h5A5A_0000;
    ch_instr[i*32 +: 32]     = {20'h0, 7'(i), rd};
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    ch_valid  = '0;
    pend_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ch_valid = '0; pend_addr = '0; flush = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (o_en[m] !== 1'b0 || o_data[m] !== '0 || o_rd[m] !== '0 || o_tag[m] !== '0 || o_instr[m] !== '0) begin
        n_fail++;
        $display("FAIL reset_wb inst%0d: got en=%0b data=%0h rd=%0d tag=%0h instr=%0h expected all 0",
                 m, o_en[m], o_data[m], o_rd[m], o_tag[m], o_instr[m]);
      end
      n_checks++;
      if (o_rdy[m] !== '1 || o_busy[m] !== 1'b0 || o_hit[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_status inst%0d: got ready=%b busy=%0b hit=%0b expected 11111/0/0",
                 m, o_rdy[m], o_busy[m], o_hit[m]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_push();
    do_reset();
    set_ch(2, 32'hDEADBEEF, 5'd5);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      tick();
      if (cyc == 1) ch_valid = '0;
      n_checks++;
      if (o_en[0] !== (cyc == 2)) begin
        n_fail++;
        $display("FAIL single_en after edge %0d: got %0b expected %0b", cyc, o_en[0], (cyc == 2));
      end
      if (cyc == 2) begin
        n_checks++;
        if (o_rd[0] !== 5'd5 || o_data[0] !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL single_payload: got rd=%0d data=%0h expected rd=5 data=deadbeef", o_rd[0], o_data[0]);
        end
      end
    end
  endtask

  task automatic test_collision();
    do_reset();
    for (int i = 0; i < NCH; i++) set_ch(i, 32'h1000 + i, 5'(i + 1));
    tick();
    ch_valid = '0;
    for (int k = 0; k < NCH; k++) begin
      tick();
      n_checks++;
      if (o_en[0] !== 1'b1 || o_rd[0] !== 5'(k + 1) || o_rd[1] !== 5'(k + 1)) begin
        n_fail++;
        $display("FAIL collision_rr0 slot%0d: got rr rd=%0d en=%0b fixed rd=%0d expected %0d",
                 k, o_rd[0], o_en[0], o_rd[1], k + 1);
      end
    end
    // move the rotation pointer to 3 by granting channel 2 alone
    set_ch(2, 32'h2222, 5'd9);
    tick();
    ch_valid = '0;
    tick();
    for (int i = 0; i < NCH; i++) set_ch(i, 32'h3000 + i, 5'(i + 1));
    tick();
    ch_valid = '0;
    for (int k = 0; k < NCH; k++) begin
      tick();
      n_checks++;
      if (o_en[0] !== 1'b1 || o_rd[0] !== 5'((k + 3) % NCH + 1)) begin
        n_fail++;
        $display("FAIL collision_rr3 slot%0d: got rd=%0d en=%0b expected %0d",
                 k, o_rd[0], o_en[0], (k + 3) % NCH + 1);
      end
      n_checks++;
      if (o_rd[1] !== 5'(k + 1)) begin
        n_fail++;
        $display("FAIL collision_fixed slot%0d: got rd=%0d expected %0d", k, o_rd[1], k + 1);
      end
    end
  endtask

  task automatic test_starvation();
    do_reset();
    set_ch(4, 32'h4444, 5'd20);
    set_ch(0, 32'h0000, 5'd10);
    tick();
    ch_valid[4] = 1'b0;
    for (int e = 2; e <= 10; e++) begin
      if (e == 9) ch_valid[0] = 1'b0;
      tick();
      n_checks++;
      if (o_en[1] !== 1'b1 || o_rd[1] !== ((e <= 9) ? 5'd10 : 5'd20)) begin
        n_fail++;
        $display("FAIL starve_fixed edge%0d: got rd=%0d en=%0b expected %0d",
                 e, o_rd[1], o_en[1], (e <= 9) ? 10 : 20);
      end
    end
  endtask

  task automatic test_backpressure();
    int   idx = 0;
    logic acc;
    logic [4:0] got [$];
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 10) set_ch(0, 32'(cyc), 5'd9);
      else ch_valid[0] = 1'b0;
      if (idx < 3) set_ch(1, 32'hB000 + 32'(idx), 5'(11 + idx));
      else ch_valid[1] = 1'b0;
      acc = ch_valid[1] & o_rdy[0][1];
      tick();
      if (acc) begin
        idx++;
        if (idx == 2) begin
          n_checks++;
          if (o_rdy[0][1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_low: got %0b expected 0", o_rdy[0][1]);
          end
        end
      end
      if (o_en[0] && o_rd[0] >= 5'd11 && o_rd[0] <= 5'd13) begin
        got.push_back(o_rd[0]);
        n_checks++;
        if (o_data[0] !== 32'hB000 + 32'(o_rd[0] - 5'd11)) begin
          n_fail++;
          $display("FAIL bp_data rd%0d: got %0h expected %0h", o_rd[0], o_data[0], 32'hB000 + 32'(o_rd[0] - 5'd11));
        end
      end
    end
    n_checks++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d writebacks expected 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got[k] !== 5'(11 + k)) begin
          n_fail++;
          $display("FAIL bp_order slot%0d: got rd=%0d expected %0d", k, got[k], 11 + k);
        end
      end
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    pend_addr = 5'd0;
    set_ch(0, 32'hC0, 5'd0);
    set_ch(1, 32'hC1, 5'd6);
    tick();
    ch_valid = '0;
    n_checks++;
    if (o_hit[0] !== 1'b0 || o_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rd0_queued: got hit=%0b busy=%0b expected 0/1", o_hit[0], o_busy[0]);
    end
    tick();
    n_checks++;
    if (o_en[0] !== 1'b0 || o_data[0] !== 32'hC0 || o_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rd0_slot: got en=%0b data=%0h busy=%0b expected 0/c0/1", o_en[0], o_data[0], o_busy[0]);
    end
    tick();
    n_checks++;
    if (o_en[0] !== 1'b1 || o_rd[0] !== 5'd6 || o_data[0] !== 32'hC1) begin
      n_fail++;
      $display("FAIL rd0_next: got en=%0b rd=%0d data=%0h expected 1/6/c1", o_en[0], o_rd[0], o_data[0]);
    end
    tick();
    n_checks++;
    if (o_en[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rd0_idle: got en=%0b busy=%0b expected 0/0", o_en[0], o_busy[0]);
    end
  endtask

  task automatic test_hazard();
    logic exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    pend_addr = 5'd7;
    #1;
    n_checks++;
    if (o_hit[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL hazard_empty: got %0b expected 0", o_hit[0]);
    end
    set_ch(3, 32'h77, 5'd7);
    for (int c = 1; c < 4; c++) begin
      tick();
      ch_valid = '0;
      n_checks++;
      if (o_hit[0] !== exp[c] || o_en[0] !== (c == 2)) begin
        n_fail++;
        $display("FAIL hazard step%0d: got hit=%0b en=%0b expected %0b/%0b", c, o_hit[0], o_en[0], exp[c], (c == 2));
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_ch(0, 32'hF0, 5'd1);
    set_ch(1, 32'hF1, 5'd2);
    set_ch(2, 32'hF2, 5'd3);
    tick();
    ch_valid = '0;
    flush = 1'b1;
    set_ch(3, 32'hF3, 5'd4);
    tick();
    flush = 1'b0;
    ch_valid = '0;
    n_checks++;
    if (o_rdy[0] !== '1 || o_busy[0] !== 1'b0 || o_en[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: got ready=%b busy=%0b en=%0b expected 11111/0/0", o_rdy[0], o_busy[0], o_en[0]);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (o_en[0] !== 1'b0 || o_en[1] !== 1'b0 || o_busy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_drain cyc%0d: got en=%0b/%0b busy=%0b expected 0", c, o_en[0], o_en[1], o_busy[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < NCH; i++) set_ch(i, 32'hA000 + i, 5'(i + 1));
    tick();
    ch_valid = '0;
    tick();
    n_checks++;
    if (o_en[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: got en=%0b expected 1", o_en[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (o_en[m] !== 1'b0 || o_data[m] !== '0 || o_rd[m] !== '0 || o_rdy[m] !== '1 || o_busy[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL arst_now inst%0d: got en=%0b data=%0h rd=%0d ready=%b busy=%0b expected 0/0/0/11111/0",
                 m, o_en[m], o_data[m], o_rd[m], o_rdy[m], o_busy[m]);
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (o_en[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL arst_lost cyc%0d: got en=%0b busy=%0b expected 0/0", c, o_en[0], o_busy[0]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      ch_valid  = NCH'($urandom);
      flush     = ($urandom_range(0, 40) == 0);
      pend_addr = 5'($urandom_range(0, 7));
      for (int i = 0; i < NCH; i++) begin
        ch_data[i*XLEN +: XLEN] = $urandom;
        ch_rd_addr[i*5 +: 5]    = 5'($urandom_range(0, 7));
        ch_tag[i*XLEN +: XLEN]  = $urandom;
        ch_instr[i*32 +: 32]    = $urandom;
      end
      tick();
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (o_en[m] !== me_en[m]) begin
          n_fail++;
          $display("FAIL rand_en inst%0d cyc%0d: got %0b expected %0b", m, cyc, o_en[m], me_en[m]);
        end
        n_checks++;
        if (o_data[m] !== me[m].data || o_rd[m] !== me[m].rd || o_tag[m] !== me[m].tag || o_instr[m] !== me[m].instr) begin
          n_fail++;
          $display("FAIL rand_payload inst%0d cyc%0d: got %0h/%0d/%0h/%0h expected %0h/%0d/%0h/%0h", m, cyc,
                   o_data[m], o_rd[m], o_tag[m], o_instr[m], me[m].data, me[m].rd, me[m].tag, me[m].instr);
        end
        n_checks++;
        if (o_rdy[m] !== exp_rdy(m)) begin
          n_fail++;
          $display("FAIL rand_ready inst%0d cyc%0d: got %b expected %b", m, cyc, o_rdy[m], exp_rdy(m));
        end
        n_checks++;
        if (o_busy[m] !== exp_busy(m)) begin
          n_fail++;
          $display("FAIL rand_busy inst%0d cyc%0d: got %0b expected %0b", m, cyc, o_busy[m], exp_busy(m));
        end
        n_checks++;
        if (o_hit[m] !== exp_hit(m)) begin
          n_fail++;
          $display("FAIL rand_hit inst%0d cyc%0d addr%0d: got %0b expected %0b", m, cyc, pend_addr, o_hit[m], exp_hit(m));
        end
      end
    end
    flush = 1'b0;
    ch_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_collision();
    test_starvation();
    test_backpressure();
    test_rd_zero();
    test_hazard();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
